// File: rtl/mac_job_sequencer_if.sv
// Job, operand-read, MAC datapath and result signals of mac_job_sequencer.
// The job_bias member exists only when BIAS_ADD_EN is defined.
interface mac_job_sequencer_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_in_base;
  logic [ADDR_W-1:0] job_flt_base;
  logic [7:0]        job_offset;
  logic [15:0]       job_len;
`ifdef BIAS_ADD_EN
  logic [31:0]       job_bias;
`endif
  logic              in_rd_en;
  logic [ADDR_W-1:0] in_rd_addr;
  logic [31:0]       in_rd_data;
  logic              flt_rd_en;
  logic [ADDR_W-1:0] flt_rd_addr;
  logic [31:0]       flt_rd_data;
  logic [127:0]      mac_in;
  logic [127:0]      mac_flt;
  logic [7:0]        mac_offset;
  logic [31:0]       mac_sum;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic              busy;

  // Sequencer side
  modport master (
`ifdef BIAS_ADD_EN
    input  job_bias,
`endif
    input  job_valid, job_in_base, job_flt_base, job_offset, job_len,
    input  in_rd_data, flt_rd_data, mac_sum, res_ready,
    output job_ready, in_rd_en, in_rd_addr, flt_rd_en, flt_rd_addr,
    output mac_in, mac_flt, mac_offset, res_valid, res_data, busy
  );

  // Job source, operand memories and MAC datapath side
  modport slave (
`ifdef BIAS_ADD_EN
    output job_bias,
`endif
    output job_valid, job_in_base, job_flt_base, job_offset, job_len,
    output in_rd_data, flt_rd_data, mac_sum, res_ready,
    input  job_ready, in_rd_en, in_rd_addr, flt_rd_en, flt_rd_addr,
    input  mac_in, mac_flt, mac_offset, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_job_sequencer.sv
// Sequences 16-byte operand blocks from two word memories into a 16-lane MAC
// and accumulates the dot products. Optional BIAS_ADD_EN adds a per-job bias.
module mac_job_sequencer #(
  parameter int unsigned ADDR_W = 12
) (
  input logic                  clk,
  input logic                  reset,
  mac_job_sequencer_if.master  bus
);

  typedef enum logic [2:0] {IDLE, START, FETCH, WAIT, MAC, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        k, k_nxt;
  logic [15:0]       blk, blk_nxt;
  logic [15:0]       len_q, len_nxt;
  logic [ADDR_W-1:0] in_base_q, in_base_nxt;
  logic [ADDR_W-1:0] flt_base_q, flt_base_nxt;
  logic [7:0]        offset_q, offset_nxt;
  logic [31:0]       acc, acc_nxt;
  logic [127:0]      in_buf, in_buf_nxt;
  logic [127:0]      flt_buf, flt_buf_nxt;
  logic              rd_en_q, rd_en_nxt;
  logic [ADDR_W-1:0] in_addr_q, in_addr_nxt;
  logic [ADDR_W-1:0] flt_addr_q, flt_addr_nxt;
  logic              res_valid_q, res_valid_nxt;
  logic [31:0]       res_data_q, res_data_nxt;
  logic              job_ready_q, job_ready_nxt;
  logic              busy_q, busy_nxt;
  logic              cap_en;
  logic [1:0]        cap_idx;
  logic [31:0]       bias_term;
`ifdef BIAS_ADD_EN
  logic [31:0]       bias_q, bias_nxt;
  assign bias_term = bias_q;
`else
  assign bias_term = 32'd0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      blk         <= '0;
      len_q       <= '0;
      in_base_q   <= '0;
      flt_base_q  <= '0;
      offset_q    <= '0;
      acc         <= '0;
      in_buf      <= '0;
      flt_buf     <= '0;
      rd_en_q     <= 1'b0;
      in_addr_q   <= '0;
      flt_addr_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef BIAS_ADD_EN
      bias_q      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      blk         <= blk_nxt;
      len_q       <= len_nxt;
      in_base_q   <= in_base_nxt;
      flt_base_q  <= flt_base_nxt;
      offset_q    <= offset_nxt;
      acc         <= acc_nxt;
      in_buf      <= in_buf_nxt;
      flt_buf     <= flt_buf_nxt;
      rd_en_q     <= rd_en_nxt;
      in_addr_q   <= in_addr_nxt;
      flt_addr_q  <= flt_addr_nxt;
      res_valid_q <= res_valid_nxt;
      res_data_q  <= res_data_nxt;
      job_ready_q <= job_ready_nxt;
      busy_q      <= busy_nxt;
`ifdef BIAS_ADD_EN
      bias_q      <= bias_nxt;
`endif
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    blk_nxt      = blk;
    len_nxt      = len_q;
    in_base_nxt  = in_base_q;
    flt_base_nxt = flt_base_q;
    offset_nxt   = offset_q;
    acc_nxt      = acc;
    in_buf_nxt   = in_buf;
    flt_buf_nxt  = flt_buf;
    res_data_nxt = res_data_q;
    cap_en       = 1'b0;
    cap_idx      = 2'd0;
`ifdef BIAS_ADD_EN
    bias_nxt     = bias_q;
`endif

    case (state)
      IDLE: begin
        if (bus.job_valid && job_ready_q) begin
          in_base_nxt  = bus.job_in_base;
          flt_base_nxt = bus.job_flt_base;
          offset_nxt   = bus.job_offset;
          len_nxt      = bus.job_len;
`ifdef BIAS_ADD_EN
          bias_nxt     = bus.job_bias;
`endif
          state_nxt    = START;
        end
      end
      START: begin
        acc_nxt   = 32'd0;
        blk_nxt   = 16'd0;
        k_nxt     = 2'd0;
        state_nxt = (len_q == 16'd0) ? DONE : FETCH;
      end
      FETCH: begin
        k_nxt = k + 2'd1;
        if (k == 2'd3) state_nxt = WAIT;
      end
      WAIT: state_nxt = MAC;
      MAC: begin
        acc_nxt   = acc + bus.mac_sum;
        blk_nxt   = blk + 16'd1;
        k_nxt     = 2'd0;
        state_nxt = (blk_nxt == len_q) ? DONE : FETCH;
      end
      DONE: begin
        if (res_valid_q && bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Word k arrives one cycle after its read; word 3 lands during WAIT
    if (state == FETCH && k != 2'd0) begin
      cap_en  = 1'b1;
      cap_idx = k - 2'd1;
    end else if (state == WAIT) begin
      cap_en  = 1'b1;
      cap_idx = 2'd3;
    end
    if (cap_en) begin
      in_buf_nxt[{cap_idx, 5'd0} +: 32]  = bus.in_rd_data;
      flt_buf_nxt[{cap_idx, 5'd0} +: 32] = bus.flt_rd_data;
    end

    rd_en_nxt    = (state_nxt == FETCH);
    in_addr_nxt  = rd_en_nxt ? in_base_q + ADDR_W'({blk_nxt, k_nxt}) : '0;
    flt_addr_nxt = rd_en_nxt ? flt_base_q + ADDR_W'({blk_nxt, k_nxt}) : '0;

    if (state_nxt == DONE && state != DONE) res_data_nxt = acc_nxt + bias_term;
    res_valid_nxt = (state_nxt == DONE);
    job_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
  end

  assign bus.job_ready   = job_ready_q;
  assign bus.busy        = busy_q;
  assign bus.in_rd_en    = rd_en_q;
  assign bus.flt_rd_en   = rd_en_q;
  assign bus.in_rd_addr  = in_addr_q;
  assign bus.flt_rd_addr = flt_addr_q;
  assign bus.mac_in      = in_buf;
  assign bus.mac_flt     = flt_buf;
  assign bus.mac_offset  = offset_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed self-checking bench for mac_job_sequencer with 1-cycle-latency
// operand memories and a bench-controlled mac_sum source.
module tb_mac_job_sequencer;
  localparam int unsigned ADDR_W = 12;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic        sum_mode;
  logic [31:0] sum_val;
  logic [31:0] in_mem  [0:4095];
  logic [31:0] flt_mem [0:4095];
`ifdef BIAS_ADD_EN
  logic [31:0] bias_val;
`endif

  mac_job_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  mac_job_sequencer #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.in_rd_en)  bus.in_rd_data  <= in_mem[bus.in_rd_addr];
    if (bus.flt_rd_en) bus.flt_rd_data <= flt_mem[bus.flt_rd_addr];
  end

  // mode 1 makes the MAC result depend on the captured lane-0 words
  assign bus.mac_sum = sum_mode ? (bus.mac_in[31:0] + bus.mac_flt[31:0]) : sum_val;
`ifdef BIAS_ADD_EN
  assign bus.job_bias = bias_val;
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic submit(input logic [11:0] ib, input logic [11:0] fb,
                        input logic [15:0] len, input logic [7:0] off);
    int n = 0;
    @(negedge clk);
    while (!bus.job_ready && n < 100) begin @(negedge clk); n++; end
    bus.job_in_base  = ib;
    bus.job_flt_base = fb;
    bus.job_len      = len;
    bus.job_offset   = off;
    bus.job_valid    = 1'b1;
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
  endtask

  // Edges after acceptance until res_valid is seen; -1 if it never rises
  task automatic wait_result(output int edges);
    edges = -1;
    for (int i = 1; i <= 500; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid) begin edges = i; break; end
    end
  endtask

  task automatic accept_result();
    @(negedge clk) bus.res_ready = 1'b1;
    @(posedge clk); #1 bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++; if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready got=%0b exp=1", bus.job_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0b exp=0", bus.res_valid); end
    checks++; if (bus.res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data got=%h exp=0", bus.res_data); end
    checks++; if ({bus.in_rd_en, bus.flt_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_rd_en got=%b exp=00", {bus.in_rd_en, bus.flt_rd_en}); end
    checks++; if ({bus.in_rd_addr, bus.flt_rd_addr} !== 24'd0) begin errors++; $display("FAIL reset_rd_addr got=%h exp=0", {bus.in_rd_addr, bus.flt_rd_addr}); end
    checks++; if ({bus.mac_in, bus.mac_flt} !== 256'd0) begin errors++; $display("FAIL reset_lanes got=%h exp=0", {bus.mac_in, bus.mac_flt}); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_len3();
    int n;
    sum_mode = 1'b0; sum_val = 32'd100;
    submit(12'h200, 12'h300, 16'd3, 8'h05);
    wait_result(n);
    checks++; if (n != 19) begin errors++; $display("FAIL len3_latency got=%0d exp=19", n); end
    checks++; if (bus.res_data !== 32'd300) begin errors++; $display("FAIL len3_res_data got=%0d exp=300", bus.res_data); end
    checks++; if ({bus.busy, bus.job_ready} !== 2'b10) begin errors++; $display("FAIL len3_done_flags got=%b exp=10", {bus.busy, bus.job_ready}); end
    accept_result();
    checks++; if ({bus.res_valid, bus.job_ready, bus.busy} !== 3'b010) begin errors++; $display("FAIL len3_back_idle got=%b exp=010", {bus.res_valid, bus.job_ready, bus.busy}); end
  endtask

  task automatic test_len0();
    int n;
    logic [31:0] exp_res;
`ifdef BIAS_ADD_EN
    bias_val = -32'sd50;
    exp_res  = 32'hFFFF_FFCE;
`else
    exp_res  = 32'd0;
`endif
    sum_mode = 1'b0; sum_val = 32'd77;
    submit(12'h123, 12'h456, 16'd0, 8'h00);
    wait_result(n);
    checks++; if (n != 1) begin errors++; $display("FAIL len0_latency got=%0d exp=1", n); end
    checks++; if (bus.res_data !== exp_res) begin errors++; $display("FAIL len0_res_data got=%h exp=%h", bus.res_data, exp_res); end
    accept_result();
`ifdef BIAS_ADD_EN
    bias_val = 32'd0;
`endif
  endtask

  task automatic test_addr_seq();
    logic [11:0] got [0:15];
    int cnt = 0;
    sum_mode = 1'b1;
    submit(12'h010, 12'h100, 16'd2, 8'hF6);
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk); #1;
      if (bus.in_rd_en) begin
        if (cnt < 16) got[cnt] = bus.in_rd_addr;
        cnt++;
      end
      if (i == 6) begin
        checks++; if (bus.mac_in[127:96] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL addr_lane3 got=%h exp=deadbeef", bus.mac_in[127:96]); end
        checks++; if (bus.mac_in[31:0] !== 32'd5) begin errors++; $display("FAIL addr_lane0_in got=%h exp=5", bus.mac_in[31:0]); end
        checks++; if (bus.mac_flt[31:0] !== 32'd7) begin errors++; $display("FAIL addr_lane0_flt got=%h exp=7", bus.mac_flt[31:0]); end
        checks++; if (bus.mac_offset !== 8'hF6) begin errors++; $display("FAIL addr_offset got=%h exp=f6", bus.mac_offset); end
      end
      if (i == 13) begin
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL addr_res_valid got=%b exp=1", bus.res_valid); end
        checks++; if (bus.res_data !== 32'd20) begin errors++; $display("FAIL addr_res_data got=%0d exp=20", bus.res_data); end
      end
    end
    checks++; if (cnt != 8) begin errors++; $display("FAIL addr_read_count got=%0d exp=8", cnt); end
    for (int j = 0; j < 8 && j < cnt; j++) begin
      checks++; if (got[j] !== 12'(12'h010 + j)) begin errors++; $display("FAIL addr_seq_%0d got=%h exp=%h", j, got[j], 12'(12'h010 + j)); end
    end
    accept_result();
  endtask

  task automatic test_wrap();
    logic [11:0] gi [0:7];
    logic [11:0] gf [0:7];
    logic [11:0] exp_in [0:3];
    int cnt = 0;
    int n;
    exp_in[0] = 12'hFFE; exp_in[1] = 12'hFFF; exp_in[2] = 12'h000; exp_in[3] = 12'h001;
    sum_mode = 1'b0; sum_val = 32'd100;
    submit(12'hFFE, 12'h020, 16'd1, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (bus.in_rd_en) begin
        if (cnt < 8) begin gi[cnt] = bus.in_rd_addr; gf[cnt] = bus.flt_rd_addr; end
        cnt++;
      end
    end
    checks++; if (cnt != 4) begin errors++; $display("FAIL wrap_read_count got=%0d exp=4", cnt); end
    for (int j = 0; j < 4 && j < cnt; j++) begin
      checks++; if (gi[j] !== exp_in[j]) begin errors++; $display("FAIL wrap_in_%0d got=%h exp=%h", j, gi[j], exp_in[j]); end
      checks++; if (gf[j] !== 12'(12'h020 + j)) begin errors++; $display("FAIL wrap_flt_%0d got=%h exp=%h", j, gf[j], 12'(12'h020 + j)); end
    end
    wait_result(n);
    checks++; if (n != 1 || bus.res_data !== 32'd100) begin errors++; $display("FAIL wrap_result edges=%0d data=%0d exp=1,100", n, bus.res_data); end
    accept_result();
  endtask

  task automatic test_hold();
    int n;
    sum_mode = 1'b0; sum_val = 32'h1234;
    submit(12'h080, 12'h090, 16'd1, 8'h3C);
    wait_result(n);
    checks++; if (n != 7) begin errors++; $display("FAIL hold_latency got=%0d exp=7", n); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.job_valid  = (i % 2 == 0);
      bus.job_offset = 8'(8'hA0 + i);
      bus.job_len    = 16'd0;
      sum_val        = 32'(32'h9000 + i);
      @(posedge clk); #1;
      checks++; if ({bus.res_valid, bus.job_ready} !== 2'b10) begin errors++; $display("FAIL hold_flags_%0d got=%b exp=10", i, {bus.res_valid, bus.job_ready}); end
      checks++; if (bus.res_data !== 32'h1234) begin errors++; $display("FAIL hold_data_%0d got=%h exp=1234", i, bus.res_data); end
    end
    @(negedge clk) bus.job_valid = 1'b0;
    accept_result();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus.busy, bus.job_ready} !== 2'b01) begin errors++; $display("FAIL hold_no_accept got=%b exp=01", {bus.busy, bus.job_ready}); end
    checks++; if (bus.mac_offset !== 8'h3C) begin errors++; $display("FAIL hold_offset got=%h exp=3c", bus.mac_offset); end
  endtask

  task automatic test_reset_mid();
    int n;
    sum_mode = 1'b0; sum_val = 32'd100;
    submit(12'h040, 12'h050, 16'd2, 8'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({bus.in_rd_en, bus.in_rd_addr} !== {1'b1, 12'h041}) begin errors++; $display("FAIL mid_fetch2 got=%b/%h exp=1/041", bus.in_rd_en, bus.in_rd_addr); end
    reset = 1'b1;
    #1;
    checks++; if ({bus.in_rd_en, bus.flt_rd_en, bus.res_valid, bus.busy} !== 4'b0000) begin errors++; $display("FAIL mid_flags got=%b exp=0000", {bus.in_rd_en, bus.flt_rd_en, bus.res_valid, bus.busy}); end
    checks++; if (bus.job_ready !== 1'b1) begin errors++; $display("FAIL mid_job_ready got=%b exp=1", bus.job_ready); end
    checks++; if ({bus.in_rd_addr, bus.flt_rd_addr} !== 24'd0) begin errors++; $display("FAIL mid_addr got=%h exp=0", {bus.in_rd_addr, bus.flt_rd_addr}); end
    checks++; if ({bus.mac_in, bus.mac_flt} !== 256'd0) begin errors++; $display("FAIL mid_lanes got=%h exp=0", {bus.mac_in, bus.mac_flt}); end
    checks++; if ({bus.mac_offset, bus.res_data} !== 40'd0) begin errors++; $display("FAIL mid_offset_data got=%h exp=0", {bus.mac_offset, bus.res_data}); end
    @(negedge clk) reset = 1'b0;
    sum_mode = 1'b1;
    submit(12'h010, 12'h100, 16'd1, 8'h01);
    wait_result(n);
    checks++; if (n != 7) begin errors++; $display("FAIL mid_next_latency got=%0d exp=7", n); end
    checks++; if (bus.res_data !== 32'd12) begin errors++; $display("FAIL mid_next_data got=%0d exp=12", bus.res_data); end
    accept_result();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      in_mem[i]  = 32'(i) ^ 32'h5A5A_0000;
      flt_mem[i] = 32'(i) ^ 32'hA5A5_0000;
    end
    in_mem[12'h010]  = 32'd5;
    in_mem[12'h013]  = 32'hDEAD_BEEF;
    in_mem[12'h014]  = 32'd11;
    flt_mem[12'h100] = 32'd7;
    flt_mem[12'h104] = 32'hFFFF_FFFD;
    bus.job_valid    = 1'b0;
    bus.res_ready    = 1'b0;
    bus.job_in_base  = '0;
    bus.job_flt_base = '0;
    bus.job_len      = '0;
    bus.job_offset   = '0;
    sum_mode         = 1'b0;
    sum_val          = 32'd0;
`ifdef BIAS_ADD_EN
    bias_val         = 32'd0;
`endif
    test_reset();
    test_len3();
    test_len0();
    test_addr_seq();
    test_wrap();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
